// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/MEM/WB/HALT FSM around a loadable
// instruction memory, 32-entry register file, ALU and word-wide data memory.
module multicycle_cpu #(
  parameter int DATA_W  = 32,
  parameter int IMEM_AW = 7,
  parameter int DMEM_AW = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               IMR,
  input  logic [31:0]        instr2load,
  input  logic [IMEM_AW-1:0] loadAdx,
  input  logic [4:0]         dbgAdx,
  output logic [DATA_W-1:0]  dbgData,
  output logic [IMEM_AW-1:0] pc,
  output logic               halted,
  output logic [15:0]        retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_BLTZ = 6'h01, OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25, F_SLT = 6'h2A;

  state_t              state_q, state_d;
  logic [IMEM_AW-1:0]  pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, mdr_q, mdr_d, alu_q, alu_d;
  logic [15:0]         retired_q, retired_d;
  logic [DATA_W-1:0]   rf_q [32];

  logic [31:0]         imem_mem [2**IMEM_AW];
  logic [DATA_W-1:0]   dmem_mem [2**DMEM_AW];

  logic [5:0]          op, funct;
  logic [4:0]          rs, rt, rd, wb_dst;
  logic [DATA_W-1:0]   imm_ext, alu_res, wb_data;
  logic                funct_ok, rf_we, dmem_we;
  logic [IMEM_AW-1:0]  pc_inc;

  assign op      = ir_q[31:26];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign funct   = ir_q[5:0];
  assign imm_ext = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
  assign pc_inc  = pc_q + IMEM_AW'(1);
  assign funct_ok = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                    (funct == F_OR)  || (funct == F_SLT);

  // R-type writes rd; ADDI and LW write rt
  assign wb_dst  = (op == OP_RTYPE) ? rd : rt;
  assign wb_data = (op == OP_LW) ? mdr_q : alu_q;

  always_comb begin
    alu_res = '0;
    if (op == OP_RTYPE) begin
      case (funct)
        F_ADD:   alu_res = a_q + b_q;
        F_SUB:   alu_res = a_q - b_q;
        F_AND:   alu_res = a_q & b_q;
        F_OR:    alu_res = a_q | b_q;
        F_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
        default: alu_res = '0;
      endcase
    end else begin
      alu_res = a_q + imm_ext;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    mdr_d     = mdr_q;
    alu_d     = alu_q;
    retired_d = retired_q;
    rf_we     = 1'b0;
    dmem_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = imem_mem[pc_q];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_d     = alu_res;
        state_d   = S_FETCH;
        pc_d      = pc_inc;
        retired_d = retired_q + 16'd1;
        case (op)
          OP_RTYPE: if (funct_ok) begin
            state_d = S_WB; pc_d = pc_q; retired_d = retired_q;
          end
          OP_ADDI: begin
            state_d = S_WB; pc_d = pc_q; retired_d = retired_q;
          end
          OP_LW, OP_SW: begin
            state_d = S_MEM; pc_d = pc_q; retired_d = retired_q;
          end
          OP_BLTZ: if (a_q[DATA_W-1]) pc_d = pc_inc + ir_q[IMEM_AW-1:0];
          OP_J:    pc_d = ir_q[IMEM_AW-1:0];
          OP_HALT: begin
            state_d = S_HALT; pc_d = pc_q; retired_d = retired_q;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (op == OP_SW) begin
          dmem_we   = 1'b1;
          pc_d      = pc_inc;
          retired_d = retired_q + 16'd1;
          state_d   = S_FETCH;
        end else begin
          mdr_d   = dmem_mem[alu_q[DMEM_AW-1:0]];
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        pc_d      = pc_inc;
        retired_d = retired_q + 16'd1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Load mode overrides everything, including a pending final-edge write
    if (IMR) begin
      state_d   = S_FETCH;
      pc_d      = '0;
      retired_d = retired_q;
      rf_we     = 1'b0;
      dmem_we   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mdr_q     <= '0;
      alu_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mdr_q     <= mdr_d;
      alu_q     <= alu_d;
      retired_q <= retired_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && (wb_dst != 5'd0)) begin
      rf_q[wb_dst] <= wb_data;
    end
  end

  // Memories carry no reset so they can map onto RAM primitives
  always_ff @(posedge clk) begin
    if (IMR) imem_mem[loadAdx] <= instr2load;
    if (dmem_we) dmem_mem[alu_q[DMEM_AW-1:0]] <= b_q;
  end

  assign dbgData = (dbgAdx == 5'd0) ? '0 : rf_q[dbgAdx];
  assign pc      = pc_q;
  assign halted  = (state_q == S_HALT);
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench for multicycle_cpu: directed and random programs compared
// against an instruction-level reference model (results, pc, retire timing).
module tb_multicycle_cpu;
  localparam int DW = 32, IAW = 7, DAW = 11, IDEPTH = 128;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            IMR = 1'b0;
  logic [31:0]     instr2load = '0;
  logic [IAW-1:0]  loadAdx = '0;
  logic [4:0]      dbgAdx = '0;
  logic [DW-1:0]   dbgData;
  logic [IAW-1:0]  pc;
  logic            halted;
  logic [15:0]     retired;

  multicycle_cpu #(.DATA_W(DW), .IMEM_AW(IAW), .DMEM_AW(DAW)) dut (
    .clk(clk), .rst(rst), .IMR(IMR), .instr2load(instr2load), .loadAdx(loadAdx),
    .dbgAdx(dbgAdx), .dbgData(dbgData), .pc(pc), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_imem [IDEPTH];
  logic [31:0] m_rf   [32];
  logic [31:0] m_dmem [int];
  int          ld_addr_q[$];
  logic [31:0] ld_word_q[$];
  int          exp_pc, exp_ret, exp_cyc, got_cyc;
  int          exp_times[$], got_times[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] f, input int rd, input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int target);
    return {6'h02, 26'(target)};
  endfunction

  function automatic void put(input int a, input logic [31:0] w);
    m_imem[a] = w;
    ld_addr_q.push_back(a);
    ld_word_q.push_back(w);
  endfunction

  // Instruction-level reference: executes the program word by word from pc 0
  task automatic run_model();
    int p, np, cyc, dst, addr;
    bit wr, done;
    logic [31:0] w, a, b, imm, res;
    p = 0; exp_ret = 0; exp_cyc = 0; done = 0;
    exp_times.delete();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    for (int step = 0; step < 5000 && !done; step++) begin
      w = m_imem[p];
      a = m_rf[w[25:21]];
      b = m_rf[w[20:16]];
      imm = {{16{w[15]}}, w[15:0]};
      np = p + 1; wr = 0; res = '0; dst = w[20:16]; cyc = 3;
      addr = int'((a + imm) & 32'h7FF);
      case (w[31:26])
        6'h00: begin
          dst = w[15:11]; cyc = 4; wr = 1;
          case (w[5:0])
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin wr = 0; cyc = 3; end
          endcase
        end
        6'h08: begin res = a + imm; wr = 1; cyc = 4; end
        6'h23: begin res = m_dmem.exists(addr) ? m_dmem[addr] : 32'd0; wr = 1; cyc = 5; end
        6'h2B: begin m_dmem[addr] = b; cyc = 4; end
        6'h01: if (a[31]) np = p + 1 + int'($signed(w[15:0]));
        6'h02: np = int'(w[25:0]);
        6'h3F: begin exp_cyc += 3; exp_pc = p; done = 1; end
        default: ;
      endcase
      if (!done) begin
        if (wr && dst != 0) m_rf[dst] = res;
        exp_cyc += cyc;
        exp_ret++;
        exp_times.push_back(exp_cyc);
        p = np & (IDEPTH - 1);
      end
    end
  endtask

  task automatic do_reset();
    IMR = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_prog();
    while (ld_addr_q.size() > 0) begin
      @(negedge clk);
      loadAdx    = IAW'(ld_addr_q.pop_front());
      instr2load = ld_word_q.pop_front();
      @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic read_reg(input int idx, output logic [31:0] val);
    dbgAdx = 5'(idx);
    #1;
    val = dbgData;
  endtask

  // Full run: reset, load, model, execute until HALT, compare architectural state
  task automatic run_prog(input string name, input int budget);
    int prev;
    logic [31:0] v;
    do_reset();
    load_prog();
    run_model();
    IMR = 1'b0;
    got_cyc = 0;
    got_times.delete();
    prev = retired;
    while (1) begin
      @(posedge clk);
      got_cyc++;
      @(negedge clk);
      if (int'(retired) != prev) begin
        got_times.push_back(got_cyc);
        prev = retired;
      end
      if (halted) break;
      if (got_cyc >= budget) begin
        check({name, "_timeout_halted"}, 32'(halted), 32'd1);
        break;
      end
    end
    $display("run %s: cycles=%0d retired=%0d pc=%0d (model cycles=%0d retired=%0d pc=%0d)",
             name, got_cyc, retired, pc, exp_cyc, exp_ret, exp_pc);
    check({name, "_cycles"}, 32'(got_cyc), 32'(exp_cyc));
    check({name, "_retired"}, 32'(retired), 32'(exp_ret));
    check({name, "_pc"}, 32'(pc), 32'(exp_pc));
    check({name, "_halted"}, 32'(halted), 32'd1);
    for (int i = 0; i < 32; i++) begin
      read_reg(i, v);
      check($sformatf("%s_r%0d", name, i), v, m_rf[i]);
    end
    check({name, "_nretire"}, 32'(got_times.size()), 32'(exp_times.size()));
    for (int i = 0; i < exp_times.size() && i < got_times.size(); i++)
      check($sformatf("%s_retire_cycle%0d", name, i), 32'(got_times[i]), 32'(exp_times[i]));
  endtask

  initial begin
    logic [31:0] v;
    int n, base, sel, target;
    for (int i = 0; i < IDEPTH; i++) m_imem[i] = '0;

    // Reset state
    #1;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    read_reg(5, v);
    check("rst_r5", v, 32'd0);

    // ADDI/ADD/HALT: r3 = 2 after 15 cycles
    put(0, enc_i(6'h08, 1, 0, 5));
    put(1, enc_i(6'h08, 2, 0, -3));
    put(2, enc_r(6'h20, 3, 1, 2));
    put(3, {6'h3F, 26'd0});
    run_prog("t1_add", 200);
    read_reg(3, v);
    check("t1_r3_const", v, 32'd2);
    check("t1_cycles_const", 32'(got_cyc), 32'd15);
    check("t1_retired_const", 32'(retired), 32'd3);
    // HALT is left by load mode
    IMR = 1'b1;
    @(posedge clk); @(negedge clk);
    check("t1_imr_leaves_halt", 32'(halted), 32'd0);
    check("t1_imr_pc0", 32'(pc), 32'd0);
    check("t1_imr_holds_retired", 32'(retired), 32'd3);

    // SW then LW through data memory
    put(0, enc_i(6'h08, 1, 0, 16'h1234));
    put(1, enc_i(6'h2B, 1, 0, 4));
    put(2, enc_i(6'h23, 4, 0, 4));
    put(3, {6'h3F, 26'd0});
    run_prog("t2_swlw", 200);
    read_reg(4, v);
    check("t2_r4_const", v, 32'h1234);
    if (got_times.size() >= 3) begin
      check("t2_sw_latency", 32'(got_times[1] - got_times[0]), 32'd4);
      check("t2_lw_latency", 32'(got_times[2] - got_times[1]), 32'd5);
    end else begin
      check("t2_retire_count", 32'(got_times.size()), 32'd3);
    end

    // BLTZ taken (r5=-1) and not taken (r5=1)
    put(0, enc_i(6'h08, 5, 0, -1));
    put(1, enc_i(6'h01, 0, 5, 2));
    put(2, enc_i(6'h08, 9, 0, 7));
    put(3, {6'h3F, 26'd0});
    put(4, {6'h3F, 26'd0});
    run_prog("t3_bltz_taken", 200);
    check("t3_taken_pc_const", 32'(pc), 32'd4);
    put(0, enc_i(6'h08, 5, 0, 1));
    run_prog("t3_bltz_not", 200);
    check("t3_not_pc_const", 32'(pc), 32'd3);
    read_reg(9, v);
    check("t3_not_r9_const", v, 32'd7);

    // SUB to all ones, signed SLT, write to r0 discarded
    put(0, enc_i(6'h08, 1, 0, 1));
    put(1, enc_r(6'h22, 6, 0, 1));
    put(2, enc_r(6'h2A, 7, 6, 0));
    put(3, enc_i(6'h08, 0, 0, 9));
    put(4, {6'h3F, 26'd0});
    run_prog("t4_sub_slt", 200);
    read_reg(6, v);
    check("t4_r6_const", v, 32'hFFFF_FFFF);
    read_reg(7, v);
    check("t4_r7_const", v, 32'd1);
    read_reg(0, v);
    check("t4_r0_const", v, 32'd0);

    // J at top of imem wraps to 0
    put(0, enc_i(6'h01, 0, 3, 2));
    put(1, enc_j(126));
    put(2, {6'h3F, 26'd0});
    put(3, {6'h3F, 26'd0});
    put(126, enc_i(6'h08, 3, 0, -1));
    put(127, enc_j(0));
    run_prog("t5_jwrap", 300);
    check("t5_pc_const", 32'(pc), 32'd3);
    // BLTZ target wraps past the top: 127 + 3 -> 2
    put(0, enc_i(6'h01, 0, 3, 2));
    put(1, enc_j(125));
    put(2, {6'h3F, 26'd0});
    put(3, enc_i(6'h08, 8, 0, 1));
    put(4, {6'h3F, 26'd0});
    put(125, enc_i(6'h08, 3, 0, -1));
    put(126, enc_i(6'h01, 0, 3, 3));
    run_prog("t5_bwrap", 300);
    check("t5_bwrap_pc_const", 32'(pc), 32'd2);

    // IMR during WB of ADD aborts the write
    do_reset();
    put(0, enc_i(6'h08, 1, 0, 5));
    put(1, enc_i(6'h08, 2, 0, 6));
    put(2, enc_r(6'h20, 3, 1, 2));
    put(3, {6'h3F, 26'd0});
    load_prog();
    IMR = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("t6_pre_retired", 32'(retired), 32'd2);
    IMR = 1'b1;
    loadAdx = '0;
    instr2load = m_imem[0];
    @(posedge clk); @(negedge clk);
    read_reg(3, v);
    check("t6_r3_unchanged", v, 32'd0);
    read_reg(1, v);
    check("t6_r1_held", v, 32'd5);
    check("t6_pc0", 32'(pc), 32'd0);
    check("t6_retired_held", 32'(retired), 32'd2);

    // Asynchronous reset in the middle of an LW
    do_reset();
    put(0, enc_i(6'h08, 1, 0, 7));
    put(1, enc_i(6'h23, 4, 0, 4));
    put(2, {6'h3F, 26'd0});
    load_prog();
    IMR = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("t7_pre_retired", 32'(retired), 32'd1);
    check("t7_pre_pc", 32'(pc), 32'd1);
    rst = 1'b1;
    #1;
    check("t7_pc", 32'(pc), 32'd0);
    check("t7_retired", 32'(retired), 32'd0);
    check("t7_halted", 32'(halted), 32'd0);
    read_reg(1, v);
    check("t7_r1", v, 32'd0);

    // Random forward-only programs; preamble clears dmem[0..7] so LW is defined
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 8; k++) put(k, enc_i(6'h2B, 0, 0, k));
      base = 8;
      n = 20;
      for (int i = base; i < base + n; i++) begin
        sel = $urandom_range(0, 11);
        case (sel)
          0: put(i, enc_r(6'h20, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
          1: put(i, enc_r(6'h22, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
          2: put(i, enc_r(6'h24, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
          3: put(i, enc_r(6'h25, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
          4: put(i, enc_r(6'h2A, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
          5, 6: put(i, enc_i(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), int'($urandom_range(0, 65535))));
          7: put(i, enc_i(6'h23, $urandom_range(0, 7), 0, $urandom_range(0, 7)));
          8: put(i, enc_i(6'h2B, $urandom_range(0, 7), 0, $urandom_range(0, 7)));
          9: put(i, enc_i(6'h01, 0, $urandom_range(0, 7), $urandom_range(0, base + n - i - 1)));
          10: begin
            target = $urandom_range(i + 1, base + n);
            put(i, enc_j(target));
          end
          default: put(i, enc_i(6'h10, $urandom_range(0, 7), $urandom_range(0, 7), 0));
        endcase
      end
      put(base + n, {6'h3F, 26'd0});
      run_prog($sformatf("rand%0d", t), 2000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Parametrised multi-cycle CPU core with internal loadable instruction memory, register file, ALU and word-wide data memory. It succeeds the single-cycle datapath, splitting every instruction into FETCH/DECODE/EXEC/MEM/WB states under one FSM. Data width and memory depths are generic. It adds branches, jumps, halt, a debug register read port and a retired-instruction counter.

## Interface
- DATA_W, 32: datapath, register and data-memory word width (>= 16)
- IMEM_AW, 7: instruction memory address bits (2^IMEM_AW 32-bit words)
- DMEM_AW, 11: data memory address bits (2^DMEM_AW DATA_W-bit words)
- clk  in  1  system clock; one clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- IMR  in  1  instruction-memory load mode; 1 = load, 0 = run
- instr2load  in  32  instruction word written in load mode
- loadAdx  in  IMEM_AW  instruction memory write address in load mode
- dbgAdx  in  5  debug register select
- dbgData  out  DATA_W  combinational read of register dbgAdx (r0 reads 0)
- pc  out  IMEM_AW  current program counter (word address)
- halted  out  1  1 while FSM is in HALT
- retired  out  16  count of completed instructions, wraps at 2^16

## Operation
- Encoding: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0], immediate sign-extended to DATA_W.
- op 0x00 R-type, rd <= rs f rt: funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT (signed, result 1/0); other funct = NOP.
- op 0x08 ADDI rt <= rs+imm; 0x23 LW rt <= dmem[(rs+imm)[DMEM_AW-1:0]]; 0x2B SW dmem[(rs+imm)[DMEM_AW-1:0]] <= rt.
- op 0x01 BLTZ: if rs[DATA_W-1]=1, pc <= pc+1+imm[IMEM_AW-1:0], else pc+1.
- op 0x02 J: pc <= instr[IMEM_AW-1:0].
- op 0x3F HALT: enter HALT. Any other op = NOP.
- Arithmetic is modulo 2^DATA_W, with no overflow trap. PC arithmetic is modulo 2^IMEM_AW (wraps).
- r0 is hardwired to 0; writes to r0 are discarded. There are 32 registers.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH latches IR <= imem[pc] -> DECODE.
  - DECODE latches A <= rs and B <= rt -> EXEC.
  - EXEC computes the ALU result.
    - BLTZ, J and NOP update pc, count as retired, go to FETCH.
    - LW and SW -> MEM. R-type and ADDI -> WB.
    - HALT -> HALT without retiring.
  - MEM: SW writes dmem, pc+1, retire -> FETCH. LW latches MDR -> WB.
  - WB writes the register file, pc+1, retire -> FETCH.
  - HALT is absorbing until reset or IMR.
- Load mode (IMR=1), every cycle:
  - imem[loadAdx] <= instr2load.
  - FSM is forced to FETCH with pc=0; retired and registers are held.
  - Register file and dmem are not written.
  - Run starts on the first clock with IMR=0.
- IMR asserted mid-instruction aborts that instruction. No partial register or memory write occurs after the abort edge.

## Timing
- Reset values:
  - pc=0, state FETCH, halted=0, retired=0, all registers 0.
  - IR, A, B, MDR and ALU-out are 0.
  - imem and dmem contents are not reset.
- Cycles per instruction:
  - BLTZ, J, NOP: 3.
  - R-type, ADDI, SW: 4.
  - LW: 5.
  - HALT: 3 edges to assert halted.
- Register and memory writes, pc update and retired increment all occur on the same final edge of the instruction.
- dbgData reflects a WB write in the cycle after that edge.
- Reset asserted mid-instruction takes effect immediately (asynchronous). Deassertion is sampled on the next edge.
- Simultaneous IMR=1 and a final-edge write: IMR wins, and the write is suppressed.

## Test plan
- Load ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; HALT -> dbgAdx=3 gives 2, retired=3, halted=1 after 3*4+3=15 run cycles.
- SW r1,4(r0) then LW r4,4(r0) with r1=0x1234 -> r4=0x1234, SW takes 4 cycles and LW takes 5 (retired increments at cycles 4 and 9).
- ADDI r5,r0,-1; BLTZ r5,+2 at pc=1 -> pc=4 next FETCH. Repeat with r5=1 -> pc=2.
- SUB r6,r0,r1 with r1=1 -> r6 = all ones. SLT r7,r6,r0 -> 1. ADDI r0,r0,9 -> r0 stays 0.
- J at pc=2^IMEM_AW-1 to 0 and BLTZ with imm wrapping past top -> pc wraps modulo 2^IMEM_AW.
- Assert IMR during the WB state of an ADD -> destination unchanged, pc=0. Assert rst mid-LW -> all outputs at reset values with no clock edge.
